// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the shift_deser serial-to-parallel receiver.
package shift_deser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deser_hold_buf.sv
// One-entry valid/ready holding register for assembled words; reports a load it had to drop.
module deser_hold_buf #(
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          sync_rst_n,
   input  logic          load,
   input  logic [DW-1:0] din,
   input  logic          par_in,
   input  logic          out_rdy,
   output logic [DW-1:0] out_data,
   output logic          out_vld,
   output logic          par_err,
   output logic          full_drop
);

   logic accept;

   // A load lands when the entry is empty or is being drained on this same edge.
   assign accept    = load & (~out_vld | out_rdy);
   assign full_drop = load & out_vld & ~out_rdy;

   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         out_data <= '0;
         out_vld  <= 1'b0;
         par_err  <= 1'b0;
      end else if (accept) begin
         out_data <= din;
         out_vld  <= 1'b1;
         par_err  <= par_in;
      end else if (out_vld && out_rdy) begin
         out_vld  <= 1'b0;
      end
   end

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: assembles DW bits MSB- or LSB-first into a one-entry output.
// Optional even-parity bit after each word when SHIFT_DESER_PARITY_EN is defined.
module shift_deser
   import shift_deser_pkg::*;
#(
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          sync_rst_n,
   input  logic          dir,
   input  logic          ser_in,
   input  logic          ser_vld,
   input  logic          frame_start,
   output logic [DW-1:0] out_data,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic          overrun,
   output logic          busy,
   output logic          par_err
);

   localparam int CNT_W = $clog2(DW + 1);

   state_t          state, state_nxt;
   logic [DW-1:0]   shreg, shreg_nxt, base_shreg;
   logic [CNT_W-1:0] bit_cnt, cnt_nxt, base_cnt;
   logic            dir_q, dir_nxt, eff_dir;
   logic            starting, last_data, complete, par_in, full_drop;

   function automatic logic [DW-1:0] shift_bit(input logic [DW-1:0] s, input logic b,
                                               input logic d);
      return (d == DIR_LSB_FIRST) ? {b, s[DW-1:1]} : {s[DW-2:0], b};
   endfunction

   // An incoming bit starts a fresh word when idle or when the frame is being restarted.
   assign starting   = frame_start | (state == IDLE);
   assign base_shreg = starting ? '0 : shreg;
   assign base_cnt   = starting ? '0 : bit_cnt;
   assign eff_dir    = starting ? dir : dir_q;
   assign last_data  = (base_cnt == CNT_W'(DW - 1));

   always_ff @(posedge clk) begin
      if (!sync_rst_n) state <= IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (frame_start) state_nxt = IDLE;
      if (ser_vld) begin
         if (starting) begin
            state_nxt = SHIFT;
         end else if (state == SHIFT && last_data) begin
`ifdef SHIFT_DESER_PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = IDLE;
`endif
         end else if (state == PAR) begin
            state_nxt = IDLE;
         end
      end
   end

   always_comb begin
      shreg_nxt = base_shreg;
      cnt_nxt   = base_cnt;
      dir_nxt   = dir_q;
      complete  = 1'b0;
      par_in    = 1'b0;
      busy      = (bit_cnt != '0) | (state == PAR);
`ifdef SHIFT_DESER_PARITY_EN
      if (ser_vld && state == PAR && !starting) begin
         complete = 1'b1;
         par_in   = ^{shreg, ser_in};
      end else if (ser_vld) begin
         shreg_nxt = shift_bit(base_shreg, ser_in, eff_dir);
         dir_nxt   = eff_dir;
         cnt_nxt   = last_data ? '0 : base_cnt + 1'b1;
      end
`else
      if (ser_vld) begin
         shreg_nxt = shift_bit(base_shreg, ser_in, eff_dir);
         dir_nxt   = eff_dir;
         cnt_nxt   = last_data ? '0 : base_cnt + 1'b1;
         complete  = last_data & ~starting;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         shreg   <= '0;
         bit_cnt <= '0;
         dir_q   <= DIR_MSB_FIRST;
         overrun <= 1'b0;
      end else begin
         shreg   <= shreg_nxt;
         bit_cnt <= cnt_nxt;
         dir_q   <= dir_nxt;
         if (full_drop) overrun <= 1'b1;
      end
   end

   deser_hold_buf #(.DW(DW)) u_hold (
      .clk        (clk),
      .sync_rst_n (sync_rst_n),
      .load       (complete),
      .din        (shreg_nxt),
      .par_in     (par_in),
      .out_rdy    (out_rdy),
      .out_data   (out_data),
      .out_vld    (out_vld),
      .par_err    (par_err),
      .full_drop  (full_drop)
   );

endmodule

// File: tb/tb_shift_deser.sv
// Self-checking bench for shift_deser: directed scenarios plus random traffic against a bit-queue model.
module tb_shift_deser;

   localparam int DW = 4;
`ifdef SHIFT_DESER_PARITY_EN
   localparam int NB = DW + 1;
`else
   localparam int NB = DW;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          sync_rst_n, dir, ser_in, ser_vld, frame_start, out_rdy;
   logic [DW-1:0] out_data;
   logic          out_vld, overrun, busy, par_err;

   shift_deser #(.DW(DW)) dut (
      .clk         (clk),
      .sync_rst_n  (sync_rst_n),
      .dir         (dir),
      .ser_in      (ser_in),
      .ser_vld     (ser_vld),
      .frame_start (frame_start),
      .out_data    (out_data),
      .out_vld     (out_vld),
      .out_rdy     (out_rdy),
      .overrun     (overrun),
      .busy        (busy),
      .par_err     (par_err)
   );

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model: the bits of the word in flight plus the holding entry.
   logic          q[$];
   logic          m_dir;
   logic [DW-1:0] m_data;
   logic          m_vld, m_ovr, m_perr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic [DW-1:0] w;
      int            ones;
      logic          done;
      if (!sync_rst_n) begin
         q.delete();
         m_dir = 1'b0; m_data = '0; m_vld = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
         return;
      end
      done = 1'b0;
      w    = '0;
      ones = 0;
      if (frame_start) q.delete();
      if (ser_vld) begin
         if (q.size() == 0) m_dir = dir;
         q.push_back(ser_in);
         if (q.size() == NB) begin
            for (int i = 0; i < DW; i++) begin
               if (m_dir) w[i] = q[i];
               else       w[DW-1-i] = q[i];
            end
            for (int i = 0; i < NB; i++) ones += int'(q[i]);
            q.delete();
            done = 1'b1;
         end
      end
      if (done) begin
         if (!m_vld || out_rdy) begin
            m_data = w;
            m_vld  = 1'b1;
`ifdef SHIFT_DESER_PARITY_EN
            m_perr = ones[0];
`else
            m_perr = 1'b0;
`endif
         end else begin
            m_ovr = 1'b1;
         end
      end else if (m_vld && out_rdy) begin
         m_vld = 1'b0;
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      chk({tag, ".data"},    32'(out_data), 32'(m_data));
      chk({tag, ".vld"},     32'(out_vld),  32'(m_vld));
      chk({tag, ".overrun"}, 32'(overrun),  32'(m_ovr));
      chk({tag, ".busy"},    32'(busy),     32'(q.size() != 0));
      chk({tag, ".par_err"}, 32'(par_err),  32'(m_perr));
   endtask

   task automatic bit_in(input logic b, input string tag);
      ser_vld = 1'b1;
      ser_in  = b;
      step(tag);
      ser_vld = 1'b0;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic send_word(input logic [DW-1:0] w, input logic d, input string tag);
      dir = d;
      for (int i = 0; i < DW; i++) bit_in(d ? w[i] : w[DW-1-i], tag);
`ifdef SHIFT_DESER_PARITY_EN
      bit_in(^w, tag);
`endif
   endtask

   initial begin
      sync_rst_n = 1'b0; dir = 1'b0; ser_in = 1'b1; ser_vld = 1'b1;
      frame_start = 1'b0; out_rdy = 1'b0;

      // Reset dominates an active serial stream
      idle(2, "rst");
      chk("rst.data0", 32'(out_data), 0);
      chk("rst.vld0",  32'(out_vld),  0);
      chk("rst.ovr0",  32'(overrun),  0);
      chk("rst.busy0", 32'(busy),     0);
      chk("rst.perr0", 32'(par_err),  0);
      sync_rst_n = 1'b1; ser_vld = 1'b0; ser_in = 1'b0;
      idle(1, "rst_rel");

      // MSB-first back-to-back
      out_rdy = 1'b1;
      send_word(4'hB, 1'b0, "msb");
      chk("msb.vld1",  32'(out_vld),  1);
      chk("msb.word",  32'(out_data), 'hB);
      chk("msb.perr",  32'(par_err),  0);
      idle(1, "msb_drain");
      chk("msb.vld0",  32'(out_vld),  0);

      // LSB-first with gaps, dir toggled mid-word
      dir = 1'b1;
      bit_in(1'b1, "lsb");
      dir = 1'b0;
      idle(1, "lsb");
      bit_in(1'b0, "lsb");
      idle(2, "lsb");
      bit_in(1'b1, "lsb");
      bit_in(1'b1, "lsb");
`ifdef SHIFT_DESER_PARITY_EN
      bit_in(1'b1, "lsb");
`endif
      chk("lsb.word", 32'(out_data), 'hD);
      chk("lsb.vld1", 32'(out_vld),  1);
      idle(1, "lsb_drain");

      // Backpressure: second word is dropped
      out_rdy = 1'b0;
      send_word(4'hA, 1'b0, "bp");
      send_word(4'h5, 1'b0, "bp");
      chk("bp.word", 32'(out_data), 'hA);
      chk("bp.ovr",  32'(overrun),  1);
      chk("bp.vld",  32'(out_vld),  1);
      out_rdy = 1'b1;
      idle(1, "bp_drain");
      chk("bp.vld0", 32'(out_vld),  0);
      chk("bp.ovr1", 32'(overrun),  1);

      // Abort via frame_start, new bit 0 in the same cycle
      dir = 1'b0;
      bit_in(1'b1, "abort");
      bit_in(1'b1, "abort");
      frame_start = 1'b1;
      bit_in(1'b0, "abort");
      frame_start = 1'b0;
      bit_in(1'b1, "abort");
      bit_in(1'b1, "abort");
      bit_in(1'b0, "abort");
`ifdef SHIFT_DESER_PARITY_EN
      bit_in(1'b0, "abort");
`endif
      chk("abort.word", 32'(out_data), 'h6);
      idle(1, "abort_drain");

      // Reset mid-word, then a clean word
      bit_in(1'b1, "rstmid");
      bit_in(1'b1, "rstmid");
      chk("rstmid.busy1", 32'(busy), 1);
      sync_rst_n = 1'b0;
      idle(1, "rstmid");
      sync_rst_n = 1'b1;
      chk("rstmid.busy0", 32'(busy),    0);
      chk("rstmid.ovr0",  32'(overrun), 0);
      send_word(4'hB, 1'b0, "rstmid");
      chk("rstmid.word",  32'(out_data), 'hB);
      idle(1, "rstmid_drain");

      // Five-bit stream: parity bit with the option, start of next word without it
      dir = 1'b0;
      bit_in(1'b1, "five"); bit_in(1'b0, "five"); bit_in(1'b1, "five"); bit_in(1'b1, "five");
`ifdef SHIFT_DESER_PARITY_EN
      bit_in(1'b0, "five");
      chk("five.word", 32'(out_data), 'hB);
      chk("five.perr", 32'(par_err),  1);
`else
      chk("five.word", 32'(out_data), 'hB);
      bit_in(1'b1, "five");
      chk("five.busy", 32'(busy),     1);
      chk("five.hold", 32'(out_data), 'hB);
`endif
      idle(1, "five");

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         sync_rst_n  = ($urandom_range(149) != 0);
         ser_vld     = ($urandom_range(9) < 7);
         ser_in      = 1'($urandom_range(1));
         dir         = 1'($urandom_range(1));
         frame_start = ($urandom_range(19) == 0);
         out_rdy     = ($urandom_range(9) < 6);
         step("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
